// File: rtl/div32_rv_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer around a 32-iteration restoring unsigned divider core.
// Optional flush input enabled by defining DIV32_RV_SEQ_FLUSH_EN.
module div32_rv_seq #(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef DIV32_RV_SEQ_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [1:0]  op_r;
  logic [31:0] a_r, b_r;
  logic [4:0]  cnt;
  logic        special;
  logic [31:0] spec_res;

  logic        flush_q;
`ifdef DIV32_RV_SEQ_FLUSH_EN
  assign flush_q = flush;
`else
  assign flush_q = 1'b0;
`endif

  logic        sgn, neg_a, neg_b, core_rst;
  logic [31:0] abs_a, abs_b;

  assign sgn      = ~op_r[0];
  assign neg_a    = sgn & a_r[31];
  assign neg_b    = sgn & b_r[31];
  assign abs_a    = neg_a ? (32'd0 - a_r) : a_r;
  assign abs_b    = neg_b ? (32'd0 - b_r) : b_r;
  assign core_rst = rst | (state != RUN);

  assign in_ready = (state == IDLE) & ~rst & ~flush_q;
  assign busy     = (state != IDLE);

  // Divider core: loads magnitudes while held in reset, one restoring step per cycle otherwise.
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [32:0] rsh;
  logic [33:0] diff;
  logic        ge;

  assign rsh  = {rem_q, quo_q[31]};
  assign diff = {1'b0, rsh} - {2'b00, dvs_q};
  assign ge   = ~diff[33];

  always_ff @(posedge clk) begin
    if (core_rst) begin
      rem_q <= '0;
      quo_q <= abs_a;
      dvs_q <= abs_b;
    end else begin
      rem_q <= ge ? diff[31:0] : rsh[31:0];
      quo_q <= {quo_q[30:0], ge};
    end
  end

  logic [31:0] q_fix, r_fix;
  assign q_fix = (sgn & (neg_a ^ neg_b) & (b_r != '0)) ? (32'd0 - quo_q) : quo_q;
  assign r_fix = neg_a ? (32'd0 - rem_q) : rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_res   <= '0;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      special   <= 1'b0;
      spec_res  <= '0;
    end else if (flush_q) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_r  <= in_op;
            a_r   <= in_a;
            b_r   <= in_b;
            state <= LOAD;
          end
        end
        // Special cases still pass through FIX so that both paths share one result register.
        LOAD: begin
          cnt     <= '0;
          special <= 1'b0;
          if (FAST_SPECIAL && (b_r == '0)) begin
            special  <= 1'b1;
            spec_res <= op_r[1] ? a_r : '1;
            state    <= FIX;
          end else if (FAST_SPECIAL && sgn && (a_r == 32'h8000_0000) && (b_r == '1)) begin
            special  <= 1'b1;
            spec_res <= op_r[1] ? 32'h0000_0000 : 32'h8000_0000;
            state    <= FIX;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          out_res   <= special ? spec_res : (op_r[1] ? r_fix : q_fix);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
